// File: rtl/bus_slave_wait_mem_if.sv
// Master->slave request bus and the slave->master return path of one slave port.
// Active-low strobes use a trailing underscore.
interface bus_slave_wait_mem_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              cs_;
  logic              as_;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );
endinterface

// File: rtl/bus_slave_wait_mem.sv
// Word-memory bus slave: accepts one request, waits WAIT_CYCLES, then answers
// with a single-cycle rdy_ (and rd_data for reads). All outputs registered.
module bus_slave_wait_mem #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_slave_wait_mem_if.slave   bus,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("bus_slave_wait_mem: WAIT_CYCLES must be in 0..15");
  end

  logic [1:0]            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [DEPTH_LOG2-1:0] idx_reg, idx_next;
  logic                  rw_reg, rw_next;
  logic [DATA_W-1:0]     wdata_reg, wdata_next;
  logic                  rdy_reg, busy_reg;
  logic [DATA_W-1:0]     rd_data_reg;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] rd_idx;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Upper address bits alias onto the same words.
  if (ADDR_W > DEPTH_LOG2) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:DEPTH_LOG2];
  end

  assign accept = (state_reg == ST_IDLE) && !bus.cs_ && !bus.as_;
  // With zero wait states the read happens on the accepting edge itself.
  assign rd_idx = (state_reg == ST_IDLE) ? bus.addr[DEPTH_LOG2-1:0] : idx_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rw_next    = rw_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          idx_next   = bus.addr[DEPTH_LOG2-1:0];
          rw_next    = bus.rw;
          wdata_next = bus.wr_data;
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = ST_ACK;
      end
      ST_ACK: begin
        cnt_next   = 4'd0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      idx_reg   <= '0;
      rw_reg    <= 1'b1;
      wdata_reg <= '0;
      rdy_reg   <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rw_reg    <= rw_next;
      wdata_reg <= wdata_next;
      rdy_reg   <= (state_next != ST_ACK);
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // Registered read port; output forced to zero outside the ACK cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (state_next == ST_ACK && rw_next) begin
      rd_data_reg <= mem[rd_idx];
    end else begin
      rd_data_reg <= '0;
    end
  end

  // Write commits at the edge that ends ACK; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (!reset && state_reg == ST_ACK && !rw_reg) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  assign bus.rdy_    = rdy_reg;
  assign bus.rd_data = rd_data_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_bus_slave_wait_mem.sv
// Directed bench: instance A (WAIT_CYCLES=2, 1024 words), instance B
// (WAIT_CYCLES=0, 16 words) for zero-wait, back-to-back and aliasing cases.
module tb_bus_slave_wait_mem;

  logic clk = 1'b0;
  logic reset;
  logic busy_a, busy_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bus_slave_wait_mem_if #(.ADDR_W(30), .DATA_W(32)) bus_a ();
  bus_slave_wait_mem_if #(.ADDR_W(30), .DATA_W(32)) bus_b ();

  bus_slave_wait_mem #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .ADDR_W(30), .DATA_W(32)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .busy(busy_a)
  );

  bus_slave_wait_mem #(.DEPTH_LOG2(4), .WAIT_CYCLES(0), .ADDR_W(30), .DATA_W(32)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .busy(busy_b)
  );

  task automatic drive(input bit sel, input logic cs, input logic as, input logic rw,
                       input logic [29:0] addr, input logic [31:0] data);
    if (sel) begin
      bus_b.cs_ = cs; bus_b.as_ = as; bus_b.rw = rw; bus_b.addr = addr; bus_b.wr_data = data;
    end else begin
      bus_a.cs_ = cs; bus_a.as_ = as; bus_a.rw = rw; bus_a.addr = addr; bus_a.wr_data = data;
    end
  endtask

  // Issues one request (called just after a falling edge) and records what the
  // slave returns over ncyc cycles; the callers compare the recordings.
  task automatic run_req(input bit sel, input logic rw, input logic [29:0] addr,
                         input logic [31:0] data, input int ncyc,
                         output logic [31:0] rdv, output logic [7:0] rdy_mask,
                         output logic [7:0] busy_mask, output bit stray);
    logic r, b;
    logic [31:0] d;
    drive(sel, 1'b0, 1'b0, rw, addr, data);
    rdv = '0; rdy_mask = '0; busy_mask = '0; stray = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b1, 1'b1, 1'b1, '0, '0);
      r = sel ? bus_b.rdy_ : bus_a.rdy_;
      d = sel ? bus_b.rd_data : bus_a.rd_data;
      b = sel ? busy_b : busy_a;
      rdy_mask[k]  = !r;
      busy_mask[k] = b;
      if (!r) rdv = d;
      else if (d != 32'h0) stray = 1'b1;
    end
    $display("txn dut=%s %s addr=0x%0h wdata=0x%0h rdata=0x%0h rdy_mask=%b busy_mask=%b",
             sel ? "B" : "A", rw ? "RD" : "WR", addr, data, rdv, rdy_mask, busy_mask);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus_a.rdy_, busy_a, bus_a.rd_data} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_a: rdy_=%b busy=%b rd_data=0x%0h, required 1/0/0", bus_a.rdy_, busy_a, bus_a.rd_data);
    end
    n_checks++;
    if ({bus_b.rdy_, busy_b, bus_b.rd_data} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_b: rdy_=%b busy=%b rd_data=0x%0h, required 1/0/0", bus_b.rdy_, busy_b, bus_b.rd_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_wait2();
    logic [31:0] rdv; logic [7:0] rm, bm; bit st;
    run_req(1'b0, 1'b0, 30'h5, 32'hDEAD_BEEF, 4, rdv, rm, bm, st);
    n_checks++;
    if (rm !== 8'b0000_1000) begin
      n_fail++; $display("FAIL write_w2_rdy: mask=%b required 00001000", rm);
    end
    n_checks++;
    if (bm !== 8'b0000_1110) begin
      n_fail++; $display("FAIL write_w2_busy: mask=%b required 00001110", bm);
    end
    n_checks++;
    if (rdv !== 32'h0 || st) begin
      n_fail++; $display("FAIL write_w2_rddata: rd_data=0x%0h stray=%0d required 0/0", rdv, st);
    end
  endtask

  task automatic test_read_wait2();
    logic [31:0] rdv; logic [7:0] rm, bm; bit st;
    run_req(1'b0, 1'b1, 30'h5, 32'h0, 4, rdv, rm, bm, st);
    n_checks++;
    if (rm !== 8'b0000_1000) begin
      n_fail++; $display("FAIL read_w2_rdy: mask=%b required 00001000", rm);
    end
    n_checks++;
    if (rdv !== 32'hDEAD_BEEF || st) begin
      n_fail++; $display("FAIL read_w2_data: rd_data=0x%0h stray=%0d required 0xdeadbeef/0", rdv, st);
    end
    // 0x405 aliases onto word 5 in a 1024-word memory.
    run_req(1'b0, 1'b1, 30'h405, 32'h0, 4, rdv, rm, bm, st);
    n_checks++;
    if (rdv !== 32'hDEAD_BEEF || rm !== 8'b0000_1000) begin
      n_fail++; $display("FAIL read_w2_alias: rd_data=0x%0h mask=%b required 0xdeadbeef/00001000", rdv, rm);
    end
  endtask

  task automatic test_ignored();
    logic [31:0] rdv; logic [7:0] rm, bm; bit st;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 30'h5, 32'h1111_1111);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.rdy_ !== 1'b1 || busy_a !== 1'b0) begin
        n_fail++; $display("FAIL cs_high_ignored: cycle %0d rdy_=%b busy=%b required 1/0", k, bus_a.rdy_, busy_a);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 30'h5, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.rdy_ !== (k == 3 ? 1'b0 : 1'b1) ||
          bus_a.rd_data !== (k == 3 ? 32'hDEAD_BEEF : 32'h0)) begin
        n_fail++; $display("FAIL strobe_in_wait: cycle %0d rdy_=%b rd_data=0x%0h required %b/0x%0h",
                           k, bus_a.rdy_, bus_a.rd_data, (k == 3 ? 1'b0 : 1'b1), (k == 3 ? 32'hDEAD_BEEF : 32'h0));
      end
      if (k == 1) drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h5, 32'h2222_2222);
      if (k == 2) drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
    end
    run_req(1'b0, 1'b1, 30'h5, 32'h0, 4, rdv, rm, bm, st);
    n_checks++;
    if (rdv !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL ignored_no_mem_change: rd_data=0x%0h required 0xdeadbeef", rdv);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rdv; logic [7:0] rm, bm; bit st;
    run_req(1'b0, 1'b0, 30'h1, 32'hCAFE_F00D, 4, rdv, rm, bm, st);
    // Reset during WAIT: no rdy_, write dropped.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h1, 32'h1234_5678);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.rdy_ !== 1'b1 || busy_a !== (k == 1)) begin
        n_fail++; $display("FAIL reset_in_wait: cycle %0d rdy_=%b busy=%b required 1/%0d", k, bus_a.rdy_, busy_a, (k == 1));
      end
      if (k == 1) begin drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '0); reset = 1'b1; end
      if (k == 2) reset = 1'b0;
    end
    run_req(1'b0, 1'b1, 30'h1, 32'h0, 4, rdv, rm, bm, st);
    n_checks++;
    if (rdv !== 32'hCAFE_F00D || rm !== 8'b0000_1000) begin
      n_fail++; $display("FAIL reset_wait_old_data: rd_data=0x%0h mask=%b required 0xcafef00d/00001000", rdv, rm);
    end
    // Reset on the edge that ends ACK: write must still be dropped.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 30'h1, 32'h0BAD_F00D);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '0);
      if (k == 3) begin
        n_checks++;
        if (bus_a.rdy_ !== 1'b0) begin
          n_fail++; $display("FAIL reset_in_ack_rdy: rdy_=%b required 0", bus_a.rdy_);
        end
        reset = 1'b1;
      end
      if (k == 4) reset = 1'b0;
    end
    run_req(1'b0, 1'b1, 30'h1, 32'h0, 4, rdv, rm, bm, st);
    n_checks++;
    if (rdv !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL reset_ack_old_data: rd_data=0x%0h required 0xcafef00d", rdv);
    end
  endtask

  task automatic test_alias_wait0();
    logic [31:0] rdv; logic [7:0] rm, bm; bit st;
    run_req(1'b1, 1'b0, 30'h13, 32'h0000_00A5, 2, rdv, rm, bm, st);
    n_checks++;
    if (rm !== 8'b0000_0010 || bm !== 8'b0000_0010) begin
      n_fail++; $display("FAIL w0_write_timing: rdy=%b busy=%b required 00000010/00000010", rm, bm);
    end
    run_req(1'b1, 1'b0, 30'h2, 32'h0000_0022, 2, rdv, rm, bm, st);
    run_req(1'b1, 1'b1, 30'h3, 32'h0, 2, rdv, rm, bm, st);
    n_checks++;
    if (rdv !== 32'h0000_00A5 || rm !== 8'b0000_0010 || st) begin
      n_fail++; $display("FAIL alias_read: rd_data=0x%0h mask=%b stray=%0d required 0xa5/00000010/0", rdv, rm, st);
    end
    run_req(1'b1, 1'b1, 30'h2, 32'h0, 2, rdv, rm, bm, st);
    n_checks++;
    if (rdv !== 32'h0000_0022) begin
      n_fail++; $display("FAIL raw_w0: rd_data=0x%0h required 0x22", rdv);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 30'h3, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_d = (k == 1 || k == 5) ? 32'h0000_00A5 : (k == 3) ? 32'h0000_0022 : 32'h0;
      n_checks++;
      if (bus_b.rdy_ !== ~k[0] || busy_b !== k[0] || bus_b.rd_data !== exp_d) begin
        n_fail++; $display("FAIL back_to_back: cycle %0d rdy_=%b busy=%b rd_data=0x%0h required %b/%b/0x%0h",
                           k, bus_b.rdy_, busy_b, bus_b.rd_data, ~k[0], k[0], exp_d);
      end
      $display("txn dut=B b2b cycle=%0d rdy_=%b rd_data=0x%0h", k, bus_b.rdy_, bus_b.rd_data);
      if (k == 2) drive(1'b1, 1'b0, 1'b0, 1'b1, 30'h2, 32'h0);
      if (k == 4) drive(1'b1, 1'b0, 1'b0, 1'b1, 30'h13, 32'h0);
      if (k == 5) drive(1'b1, 1'b1, 1'b1, 1'b1, '0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_write_wait2();
    test_read_wait2();
    test_ignored();
    test_reset_abort();
    test_alias_wait0();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
